sweep_sequencer: RTL
====================

// Module: sweep_sequencer
// PURPOSE
//  Sequences the 9-bit prescaled step counter for one cytometer scan: clears it, lets it advance one step
//  at a time, holds it while the ADC path captures a sample at each index, and repeats for N sweeps.
//  Sits between the run-control logic (START/ABORT) and the counter (ENABLE/RESET in, DATA out) plus capture.
// PARAMETERS
//  DATA_W         9     counter/index width; last index = 2**DATA_W-1
//  SWEEP_W        8     width of sweep count and sweep index
//  SETTLE_CYCLES  16    CLOCK_IN cycles waited after each index change before SAMPLE_REQ (>=1)
//  ACK_TIMEOUT    1024  max cycles SAMPLE_REQ may stay unacknowledged before error abort (>=2)
// PORTS
//  CLOCK_IN     in   1        system clock
//  RESET        in   1        synchronous, active-high reset
//  START        in   1        1-cycle pulse; begin scan (ignored while BUSY)
//  ABORT        in   1        level/pulse; stop scan, return counter to 0
//  NUM_SWEEPS   in   SWEEP_W  sweeps per scan, latched on accepted START; 0 = continuous until ABORT
//  CNT_DATA     in   DATA_W   counter current index
//  CNT_ENABLE   out  1        drives counter ENABLE
//  CNT_RESET    out  1        drives counter RESET
//  SAMPLE_REQ   out  1        request capture of SAMPLE_ADDR; held until SAMPLE_ACK
//  SAMPLE_ACK   in   1        capture done; accepted only while SAMPLE_REQ=1
//  SAMPLE_ADDR  out  DATA_W   index being sampled, stable while SAMPLE_REQ=1
//  SWEEP_IDX    out  SWEEP_W  current sweep number, 0-based, wraps in continuous mode
//  BUSY         out  1        1 in every state except IDLE
//  DONE         out  1        1-cycle pulse on normal scan completion
//  ERROR        out  1        sticky; set on ACK timeout, cleared by RESET or accepted START
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, all outputs 0, SWEEP_IDX=0, internal counters 0.
//  - States: IDLE, CLEAR, RUN, SETTLE, SAMPLE, NEXT, STOPPING.
//  - IDLE: START & !ABORT -> CLEAR; latch NUM_SWEEPS, SWEEP_IDX<=0, ERROR<=0. START&ABORT same cycle: stay IDLE.
//  - CLEAR: CNT_RESET=1, CNT_ENABLE=0; counter honours RESET only on its prescale tick, so hold until
//    CNT_DATA==0 observed, then CNT_RESET<=0, latch last<=0 -> SETTLE (index 0 is sampled first).
//  - RUN: CNT_ENABLE=1; on CNT_DATA!=last: CNT_ENABLE<=0 next cycle, last<=CNT_DATA -> SETTLE.
//    Counter prescale period must be >=2 CLOCK_IN cycles so a single step occurs per RUN.
//  - SETTLE: count SETTLE_CYCLES cycles, then SAMPLE_REQ<=1, SAMPLE_ADDR<=last -> SAMPLE.
//  - SAMPLE: wait SAMPLE_ACK; on ACK: SAMPLE_REQ<=0 -> NEXT. If ACK_TIMEOUT cycles pass with REQ high:
//    SAMPLE_REQ<=0, ERROR<=1 -> STOPPING (no DONE).
//  - NEXT (1 cycle): if last != 2**DATA_W-1 -> RUN. Else sweep complete: if NUM_SWEEPS!=0 and
//    SWEEP_IDX==NUM_SWEEPS-1 -> STOPPING with DONE pending; else SWEEP_IDX+1 -> RUN (counter wraps to 0).
//  - STOPPING: CNT_ENABLE=0, CNT_RESET=1 until CNT_DATA==0, then CNT_RESET<=0; DONE=1 for one cycle
//    if pending (normal end) -> IDLE.
//  - ABORT in any state except IDLE/STOPPING: next cycle SAMPLE_REQ=0, CNT_ENABLE=0 -> STOPPING, no DONE.
//    ABORT beats SAMPLE_ACK and timeout in the same cycle; late ACK after abort is ignored.
//  - START while BUSY ignored. ABORT in IDLE no effect.
//  - Handshake: SAMPLE_ADDR never changes while SAMPLE_REQ=1; one REQ per index per sweep.
// TESTING (bench models counter: tick every 8 cycles, DATA_W=4 override, SETTLE_CYCLES=2)
//  1 NUM_SWEEPS=1, ACK 3 cycles after REQ -> REQs for addr 0..15 in order, counter cleared, one DONE, BUSY falls.
//  2 NUM_SWEEPS=3 -> 48 REQs, SWEEP_IDX 0,1,2, wrap 15->0 sampled as addr 0, DONE once at end.
//  3 ACK never returns on addr 5 -> REQ drops after ACK_TIMEOUT cycles, ERROR=1, CNT_DATA returns 0, no DONE.
//  4 ABORT during SETTLE at addr 7 -> no further REQ, CNT_RESET high until CNT_DATA=0, IDLE, no DONE.
//  5 NUM_SWEEPS=0, run 40 steps, ABORT -> continuous sweeps, SWEEP_IDX increments at each 15->0.
//  6 START during scan, START+ABORT in IDLE, RESET mid-SAMPLE -> ignored, stays IDLE, all outputs 0 next cycle.

Source files
------------

// File: rtl/sweep_sequencer.sv
// ----------------------------------------------------------------------------
// sweep_sequencer
//   Sequences an external prescaled step counter through one cytometer scan.
//   The counter is cleared, released one step at a time, held while the ADC
//   path captures a sample at each index, and the whole sweep is repeated
//   NUM_SWEEPS times (0 = continuous until ABORT).
//
// Ports
//   CLOCK_IN     system clock
//   RESET        synchronous, active-high reset
//   START        1-cycle pulse, begins a scan (ignored while BUSY)
//   ABORT        stops the scan and returns the counter to 0
//   NUM_SWEEPS   sweeps per scan, latched on an accepted START
//   CNT_DATA     counter current index
//   CNT_ENABLE   counter ENABLE
//   CNT_RESET    counter RESET (only honoured on the counter's prescale tick)
//   SAMPLE_REQ   capture request for SAMPLE_ADDR, held until SAMPLE_ACK
//   SAMPLE_ACK   capture done, only meaningful while SAMPLE_REQ=1
//   SAMPLE_ADDR  index being sampled
//   SWEEP_IDX    current sweep number (0-based, wraps in continuous mode)
//   BUSY         high in every state except IDLE
//   DONE         1-cycle pulse on normal completion
//   ERROR        sticky acknowledge-timeout flag
// ----------------------------------------------------------------------------
module sweep_sequencer #(
  parameter int DATA_W        = 9,
  parameter int SWEEP_W       = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int ACK_TIMEOUT   = 1024
) (
  input  logic               CLOCK_IN,
  input  logic               RESET,
  input  logic               START,
  input  logic               ABORT,
  input  logic [SWEEP_W-1:0] NUM_SWEEPS,
  input  logic [DATA_W-1:0]  CNT_DATA,
  output logic               CNT_ENABLE,
  output logic               CNT_RESET,
  output logic               SAMPLE_REQ,
  input  logic               SAMPLE_ACK,
  output logic [DATA_W-1:0]  SAMPLE_ADDR,
  output logic [SWEEP_W-1:0] SWEEP_IDX,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERROR
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLEAR    = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_SAMPLE   = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_STOPPING = 3'd6;

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] LAST_IDX    = {DATA_W{1'b1}};

  logic [2:0]         state_q,  state_d;
  logic               cnt_en_q, cnt_en_d;
  logic               cnt_rst_q, cnt_rst_d;
  logic               req_q,    req_d;
  logic [DATA_W-1:0]  addr_q,   addr_d;
  logic [SWEEP_W-1:0] sweep_q,  sweep_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               err_q,    err_d;
  logic [DATA_W-1:0]  last_q,   last_d;
  logic [SWEEP_W-1:0] nsw_q,    nsw_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [TO_W-1:0]    to_q,     to_d;
  logic               pend_q,   pend_d;   // normal end reached, DONE owed on leaving STOPPING
  logic               abort_ok;

  // ABORT only matters while a scan is in flight and the counter is not
  // already being returned to 0.
  assign abort_ok = ABORT && (state_q != S_IDLE) && (state_q != S_STOPPING);

  always_comb begin
    state_d  = state_q;
    cnt_en_d = cnt_en_q;
    cnt_rst_d = cnt_rst_q;
    req_d    = req_q;
    addr_d   = addr_q;
    sweep_d  = sweep_q;
    done_d   = 1'b0;
    err_d    = err_q;
    last_d   = last_q;
    nsw_d    = nsw_q;
    settle_d = settle_q;
    to_d     = to_q;
    pend_d   = pend_q;

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          nsw_d     = NUM_SWEEPS;
          sweep_d   = '0;
          err_d     = 1'b0;
          pend_d    = 1'b0;
          cnt_en_d  = 1'b0;
          cnt_rst_d = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // The counter only applies RESET on its prescale tick, so wait until
        // the cleared value is actually visible. Index 0 is sampled first.
        if (CNT_DATA == '0) begin
          cnt_rst_d = 1'b0;
          last_d    = '0;
          settle_d  = '0;
          state_d   = S_SETTLE;
        end
      end
      S_RUN: begin
        // Enable drops the cycle after the step is seen; the counter's
        // prescale period (>=2 cycles) guarantees exactly one step.
        if (CNT_DATA != last_q) begin
          cnt_en_d = 1'b0;
          last_d   = CNT_DATA;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          req_d   = 1'b1;
          addr_d  = last_q;
          to_d    = '0;
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      S_SAMPLE: begin
        if (SAMPLE_ACK) begin
          req_d   = 1'b0;
          state_d = S_NEXT;
        end else if (to_q == TO_LAST) begin
          req_d     = 1'b0;
          err_d     = 1'b1;
          cnt_rst_d = 1'b1;
          state_d   = S_STOPPING;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_NEXT: begin
        if (last_q != LAST_IDX) begin
          cnt_en_d = 1'b1;
          state_d  = S_RUN;
        end else if ((nsw_q != '0) && (sweep_q == nsw_q - SWEEP_W'(1))) begin
          pend_d    = 1'b1;
          cnt_rst_d = 1'b1;
          state_d   = S_STOPPING;
        end else begin
          // Counter wraps LAST_IDX -> 0; RUN sees the change and samples 0.
          sweep_d  = sweep_q + SWEEP_W'(1);
          cnt_en_d = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_STOPPING: begin
        cnt_en_d  = 1'b0;
        cnt_rst_d = 1'b1;
        if (CNT_DATA == '0) begin
          cnt_rst_d = 1'b0;
          done_d    = pend_q;
          pend_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // ABORT wins over ACK, timeout and sweep advance in the same cycle.
    if (abort_ok) begin
      req_d     = 1'b0;
      cnt_en_d  = 1'b0;
      cnt_rst_d = 1'b1;
      pend_d    = 1'b0;
      err_d     = err_q;
      sweep_d   = sweep_q;
      state_d   = S_STOPPING;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_en_q  <= 1'b0;
      cnt_rst_q <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      sweep_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      last_q    <= '0;
      nsw_q     <= '0;
      settle_q  <= '0;
      to_q      <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_en_q  <= cnt_en_d;
      cnt_rst_q <= cnt_rst_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      sweep_q   <= sweep_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      last_q    <= last_d;
      nsw_q     <= nsw_d;
      settle_q  <= settle_d;
      to_q      <= to_d;
      pend_q    <= pend_d;
    end
  end

  assign CNT_ENABLE  = cnt_en_q;
  assign CNT_RESET   = cnt_rst_q;
  assign SAMPLE_REQ  = req_q;
  assign SAMPLE_ADDR = addr_q;
  assign SWEEP_IDX   = sweep_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign ERROR       = err_q;

endmodule
